// File: rtl/stage_6_combined.sv
// stage_6_combined
// ----------------
// Clocked model of a six-stage bundled-data micropipeline. Tokens are taken
// from upstream with a four-phase req/ack handshake. They ripple forward through
// the stage latches as bubbles allow. They are offered downstream with a second
// four-phase handshake. The block acts as an elastic FIFO between two handshake
// domains that share one clock.
//
// Handshake rules, both sides (four-phase, return-to-zero):
//   1. The sender raises req with its data valid.
//   2. The receiver raises ack once it has taken the data.
//   3. The sender drops req.
//   4. The receiver drops ack.
//   Data stays stable from the rise of req until the rise of ack.
//
// Ports:
//   clk      - single clock; all state updates on the rising edge
//   rst      - synchronous reset, active-low
//   req_in   - upstream request; data_in is valid while high
//   ack_out  - acknowledge to upstream (registered)
//   data_in  - upstream token
//   req_out  - downstream request; data_out is valid while high (registered)
//   ack_in   - downstream acknowledge of req_out
//   data_out - token offered downstream; holds its last value while req_out is low
module stage_6_combined #(
    parameter int DATA_W = 3,
    parameter int STAGES = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic              ack_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              req_out,
    output logic              ack_out,
    output logic [DATA_W-1:0] data_out
);

    typedef enum logic {IN_IDLE, IN_WAIT} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_REQ} out_state_t;

    in_state_t  in_state, in_next;
    out_state_t out_state, out_next;

    logic [STAGES-1:0] full;
    logic [STAGES-1:0] full_next;
    logic [DATA_W-1:0] data [STAGES];

    logic              load0;
    logic [STAGES-2:0] adv;
    logic              launch;
    logic              consume;

    // Every decision below uses state from the start of the cycle. A token
    // only moves into a stage that was empty at the start of the cycle. So a
    // load into stage 0 and an advance can never target the same stage.
    always_comb begin
        load0   = (in_state == IN_IDLE) && req_in && !full[0];
        adv     = '0;
        for (int i = 0; i < STAGES - 1; i++) begin
            adv[i] = full[i] && !full[i+1];
        end
        // A lingering ack_in from the previous transfer must return low first.
        launch  = (out_state == OUT_IDLE) && full[STAGES-1] && !ack_in;
        consume = (out_state == OUT_REQ) && ack_in;
    end

    always_comb begin
        full_next = full;
        if (load0) begin
            full_next[0] = 1'b1;
        end
        for (int i = 0; i < STAGES - 1; i++) begin
            if (adv[i]) begin
                full_next[i]   = 1'b0;
                full_next[i+1] = 1'b1;
            end
        end
        // The last stage stays full for the whole OUT_REQ phase. It is freed
        // only when downstream acknowledges.
        if (consume) begin
            full_next[STAGES-1] = 1'b0;
        end
    end

    // State registers for both handshake controllers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_state  <= IN_IDLE;
            out_state <= OUT_IDLE;
        end else begin
            in_state  <= in_next;
            out_state <= out_next;
        end
    end

    // Next-state logic.
    always_comb begin
        in_next = in_state;
        case (in_state)
            IN_IDLE: if (load0)   in_next = IN_WAIT;
            IN_WAIT: if (!req_in) in_next = IN_IDLE;
            default: in_next = IN_IDLE;
        endcase

        out_next = out_state;
        case (out_state)
            OUT_IDLE: if (launch)  out_next = OUT_REQ;
            OUT_REQ:  if (consume) out_next = OUT_IDLE;
            default:  out_next = OUT_IDLE;
        endcase
    end

    // Output decode. The handshake outputs are pure functions of the state
    // registers, so there is no input-to-output combinational path.
    always_comb begin
        ack_out = (in_state == IN_WAIT);
        req_out = (out_state == OUT_REQ);
    end

    // Stage datapath and the registered output token.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full     <= '0;
            data_out <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data[i] <= '0;
            end
        end else begin
            full <= full_next;
            if (load0) begin
                data[0] <= data_in;
            end
            for (int i = 0; i < STAGES - 1; i++) begin
                if (adv[i]) begin
                    data[i+1] <= data[i];
                end
            end
            if (launch) begin
                data_out <= data[STAGES-1];
            end
        end
    end

endmodule

// File: tb/tb_stage_6_combined.sv
// Bench for stage_6_combined.
// The reference model keeps the tokens in flight as an ordered queue. Each
// token carries a stage position. Each cycle a token steps forward when the
// position ahead was vacant at the start of the cycle. The model also tracks
// the two handshake outputs. A scoreboard queue holds the tokens acknowledged
// upstream, in order. Each completed downstream transfer is checked against it.
module tb_stage_6_combined;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_in;
    logic       ack_in;
    logic [2:0] data_in;
    logic       req_out;
    logic       ack_out;
    logic [2:0] data_out;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    logic [2:0] exp_q[$];

    // Model state.
    logic [2:0] tok_val[$];
    int         tok_pos[$];
    bit         occ[6];
    logic       m_ack  = 1'b0;
    logic       m_req  = 1'b0;
    logic [2:0] m_dout = 3'd0;

    stage_6_combined #(.DATA_W(3), .STAGES(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .ack_in   (ack_in),
        .data_in  (data_in),
        .req_out  (req_out),
        .ack_out  (ack_out),
        .data_out (data_out)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, stepped at each rising edge with the sampled inputs.
    always @(posedge clk) begin
        if (!rst) begin
            tok_val.delete();
            tok_pos.delete();
            m_ack  = 1'b0;
            m_req  = 1'b0;
            m_dout = 3'd0;
        end else begin
            for (int i = 0; i < 6; i++) occ[i] = 1'b0;
            foreach (tok_pos[j]) occ[tok_pos[j]] = 1'b1;
            // Downstream side. The oldest token is the one at the exit.
            if (m_req) begin
                if (ack_in) begin
                    m_req = 1'b0;
                    void'(tok_val.pop_front());
                    void'(tok_pos.pop_front());
                end
            end else if (occ[5] && !ack_in) begin
                m_req  = 1'b1;
                m_dout = tok_val[0];
            end
            // Bubble movement: a token steps only into a place empty at cycle start.
            foreach (tok_pos[j]) begin
                if (tok_pos[j] < 5 && !occ[tok_pos[j] + 1]) tok_pos[j]++;
            end
            // Upstream side.
            if (!m_ack) begin
                if (req_in && !occ[0]) begin
                    tok_val.push_back(data_in);
                    tok_pos.push_back(0);
                    m_ack = 1'b1;
                end
            end else if (!req_in) begin
                m_ack = 1'b0;
            end
        end
    end

    // Compare process: every cycle against the model, plus the scoreboard on
    // each completed output transfer.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("ack_out", 32'(ack_out), 32'(m_ack));
            check("req_out", 32'(req_out), 32'(m_req));
            check("data_out", 32'(data_out), 32'(m_dout));
            if (rst && req_out && ack_in) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("sb_token", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: one full four-phase input cycle for token v.
    task automatic send_token(input logic [2:0] v);
        int n = 0;
        data_in = v;
        req_in  = 1'b1;
        while (!ack_out && n < 30) begin tick(); n++; end
        check("ack_rise", 32'(ack_out), 32'd1);
        exp_q.push_back(v);
        req_in = 1'b0;
        n = 0;
        tick();
        while (ack_out && n < 10) begin tick(); n++; end
        check("ack_fall", 32'(ack_out), 32'd0);
    endtask

    // Driver: one full four-phase output cycle.
    task automatic recv();
        int n = 0;
        while (!req_out && n < 40) begin tick(); n++; end
        check("req_wait", 32'(req_out), 32'd1);
        ack_in = 1'b1;
        n = 0;
        tick();
        while (req_out && n < 10) begin tick(); n++; end
        check("req_drop", 32'(req_out), 32'd0);
        ack_in = 1'b0;
        tick();
    endtask

    initial begin
        // Test 1: reset held with active inputs.
        rst = 1'b0; req_in = 1'b1; ack_in = 1'b1; data_in = 3'd5;
        tick();
        cmp_on = 1'b1;
        tick();
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_req", 32'(req_out), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        // Release: the pending request is captured; ack_in high blocks req_out.
        rst = 1'b1;
        send_token(3'd5);
        for (int i = 0; i < 10; i++) tick();
        check("blocked_req", 32'(req_out), 32'd0);
        // Test 5: lowering ack_in launches the waiting token next edge.
        ack_in = 1'b0;
        tick();
        check("unblock_req", 32'(req_out), 32'd1);
        check("unblock_data", 32'(data_out), 32'd5);
        recv();

        // Test 2: single token with exact latency.
        data_in = 3'd1; req_in = 1'b1;
        tick();
        check("lat_ack_k", 32'(ack_out), 32'd1);
        exp_q.push_back(3'd1);
        req_in = 1'b0;
        tick();
        check("lat_ack_drop", 32'(ack_out), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("lat_req_k5", 32'(req_out), 32'd0);
        tick();
        check("lat_req_k6", 32'(req_out), 32'd1);
        check("lat_data_k6", 32'(data_out), 32'd1);
        ack_in = 1'b1;
        tick();
        check("lat_req_drop", 32'(req_out), 32'd0);
        ack_in = 1'b0;
        tick();

        // Test 3: stream with a prompt downstream.
        fork
            begin
                send_token(3'd2); send_token(3'd3); send_token(3'd4); send_token(3'd6);
            end
            begin
                recv(); recv(); recv(); recv();
            end
        join
        check("stream_drain", 32'(exp_q.size()), 32'd0);

        // Test 4: fill to capacity, then a 7th request stalls.
        for (int v = 1; v <= 6; v++) send_token(3'(v));
        data_in = 3'd7; req_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("full_stall_ack", 32'(ack_out), 32'd0);
            check("full_req", 32'(req_out), 32'd1);
            check("full_data", 32'(data_out), 32'd1);
        end
        recv();
        send_token(3'd7);
        for (int i = 0; i < 6; i++) recv();
        check("fill_drain", 32'(exp_q.size()), 32'd0);

        // Test 6: reset with tokens in flight and req_out high.
        send_token(3'd3); send_token(3'd5); send_token(3'd7);
        begin
            int n = 0;
            while (!req_out && n < 20) begin tick(); n++; end
            check("mid_req", 32'(req_out), 32'd1);
        end
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("mid_rst_ack", 32'(ack_out), 32'd0);
        check("mid_rst_req", 32'(req_out), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("no_stale_req", 32'(req_out), 32'd0);
        check("no_stale_data", 32'(data_out), 32'd0);

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
